// File: rtl/light_organ_ctrl.sv
// Light-organ driver: per-channel peak-hold envelopes that drive the MiSTer LEDs by PWM
// (mode 00) or an external serial lamp chain on USER_OUT (mode 01).
module light_organ_ctrl #(
    parameter int CHANNELS     = 3,
    parameter int LEVEL_W      = 8,
    parameter int PWM_W        = 8,
    parameter int DECAY_SHIFT  = 3,
    parameter int LAMPS_PER_CH = 4,
    parameter int SHIFT_DIV    = 2
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        sample_ce,
    input  logic [CHANNELS*LEVEL_W-1:0] level,
    input  logic [1:0]                  mode,
    output logic                        led_user,
    output logic [1:0]                  led_power,
    output logic [1:0]                  led_disk,
    output logic [6:0]                  user_out,
    output logic                        busy
);

    localparam int  NBITS   = CHANNELS * LAMPS_PER_CH;
    localparam int  LAMP_W  = LEVEL_W + $clog2(LAMPS_PER_CH) + 1;
    localparam int  BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int  DIV_W   = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
    localparam bit  HAS_CH1 = (CHANNELS >= 2);
    localparam bit  HAS_CH2 = (CHANNELS >= 3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    logic [LEVEL_W-1:0] r_env [CHANNELS];
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               r_led_user;
    logic [1:0]         r_led_power;
    logic [1:0]         r_led_disk;

    state_t             r_state;
    logic [NBITS-1:0]   r_shreg;
    logic [DIV_W-1:0]   r_div;
    logic               r_phase;
    logic [BIT_W-1:0]   r_bit;
    logic               r_busy;
    logic               r_sdata;
    logic               r_sclk;
    logic               r_latch;
    logic               r_serial_en;

    logic [LEVEL_W-1:0] w_level [CHANNELS];
    logic [LEVEL_W-1:0] w_decay [CHANNELS];
    logic [2:0]         w_pwm_pad;
    logic [NBITS-1:0]   w_lamps;
    logic [NBITS-1:0]   w_shreg_next;
    logic               w_mode_led;
    logic               w_mode_ser;

    assign w_mode_led   = (mode == 2'b00);
    assign w_mode_ser   = (mode == 2'b01);
    assign w_shreg_next = r_shreg << 1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_pwm_pad = '0;
        w_lamps   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_level[i] = level[i*LEVEL_W +: LEVEL_W];
            w_decay[i] = r_env[i] - (r_env[i] >> DECAY_SHIFT);
            for (int k = 0; k < LAMPS_PER_CH; k++)
                w_lamps[i*LAMPS_PER_CH + k] =
                    (LAMP_W'(r_env[i]) * LAMP_W'(LAMPS_PER_CH)) > (LAMP_W'(k) << LEVEL_W);
        end
        // Only the first three channels have a MiSTer LED to drive.
        for (int i = 0; i < CHANNELS && i < 3; i++)
            w_pwm_pad[i] = r_env[i][LEVEL_W-1 -: PWM_W] > r_pwm_cnt;
    end

    // NOTE: the envelope array is a handful of flops, not a RAM, so it is cleared on reset like any register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                r_env[i] <= '0;
        end else if (sample_ce) begin
            for (int i = 0; i < CHANNELS; i++)
                r_env[i] <= (w_level[i] > w_decay[i]) ? w_level[i] : w_decay[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_led_user  <= 1'b0;
            r_led_power <= 2'b00;
            r_led_disk  <= 2'b00;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + PWM_W'(1);
            r_led_user  <= w_mode_led & w_pwm_pad[0];
            r_led_power <= (w_mode_led && HAS_CH1) ? {1'b1, w_pwm_pad[1]} : 2'b00;
            r_led_disk  <= (w_mode_led && HAS_CH2) ? {1'b1, w_pwm_pad[2]} : 2'b00;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_div       <= '0;
            r_phase     <= 1'b0;
            r_bit       <= '0;
            r_busy      <= 1'b0;
            r_sdata     <= 1'b0;
            r_sclk      <= 1'b0;
            r_latch     <= 1'b0;
            r_serial_en <= 1'b0;
        end else begin
            r_serial_en <= w_mode_ser;
            if (!w_mode_ser) begin
                // Leaving serial mode abandons any transfer immediately.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_sdata <= 1'b0;
                r_sclk  <= 1'b0;
                r_latch <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_pwm_cnt == '0) begin
                            r_state <= ST_SHIFT;
                            r_shreg <= w_lamps;
                            r_sdata <= w_lamps[NBITS-1];
                            r_sclk  <= 1'b0;
                            r_latch <= 1'b0;
                            r_div   <= '0;
                            r_phase <= 1'b0;
                            r_bit   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            if (!r_phase) begin
                                r_phase <= 1'b1;
                                r_sclk  <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                r_sclk  <= 1'b0;
                                if (r_bit == BIT_LAST) begin
                                    r_state <= ST_LATCH;
                                    r_sdata <= 1'b0;
                                    r_latch <= 1'b1;
                                end else begin
                                    r_bit   <= r_bit + BIT_W'(1);
                                    r_shreg <= w_shreg_next;
                                    r_sdata <= w_shreg_next[NBITS-1];
                                end
                            end
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    ST_LATCH: begin
                        if (r_div == DIV_LAST) begin
                            r_div   <= '0;
                            r_state <= ST_IDLE;
                            r_latch <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign led_user  = r_led_user;
    assign led_power = r_led_power;
    assign led_disk  = r_led_disk;
    assign busy      = r_busy;
    assign user_out  = r_serial_en ? {4'b1111, r_latch, r_sclk, r_sdata} : 7'h7F;

endmodule

// File: tb/tb_light_organ_ctrl.sv
// Self-checking bench for light_organ_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-count-based behavioural model.
module tb_light_organ_ctrl;

    localparam int CH = 3, LW = 8, PW = 8, DS = 3, L = 4, SD = 2;
    localparam int NB = CH * L;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             sample_ce;
    logic [CH*LW-1:0] level;
    logic [1:0]       mode;
    logic             led_user;
    logic [1:0]       led_power;
    logic [1:0]       led_disk;
    logic [6:0]       user_out;
    logic             busy;

    always #5 clk_sys = ~clk_sys;

    light_organ_ctrl #(
        .CHANNELS(CH), .LEVEL_W(LW), .PWM_W(PW), .DECAY_SHIFT(DS),
        .LAMPS_PER_CH(L), .SHIFT_DIV(SD)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce), .level(level),
        .mode(mode), .led_user(led_user), .led_power(led_power), .led_disk(led_disk),
        .user_out(user_out), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: envelopes as integers, PWM as a cycle count, serial frame as an offset t.
    int          m_env [CH];
    int          m_cnt;
    bit          m_active;
    int          m_t;
    bit [NB-1:0] m_bits;
    logic        m_led_user  = 1'b0;
    logic [1:0]  m_led_power = 2'b00;
    logic [1:0]  m_led_disk  = 2'b00;
    logic [6:0]  m_user_out  = 7'h7F;
    logic        m_busy      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit [NB-1:0] lamp_bits();
        bit [NB-1:0] b = '0;
        for (int i = 0; i < CH; i++)
            for (int k = 0; k < L; k++)
                b[i*L + k] = (m_env[i] * L) > (k * (1 << LW));
        return b;
    endfunction

    task automatic model_step();
        bit pw [3];
        int dec, lv;
        if (reset) begin
            for (int i = 0; i < CH; i++) m_env[i] = 0;
            m_cnt = 0; m_active = 0; m_t = 0;
            m_led_user = 0; m_led_power = 0; m_led_disk = 0;
            m_user_out = 7'h7F; m_busy = 0;
            return;
        end
        for (int i = 0; i < 3; i++) pw[i] = 0;
        for (int i = 0; i < CH && i < 3; i++) pw[i] = (m_env[i] >> (LW - PW)) > m_cnt;
        m_led_user  = (mode == 2'b00) ? pw[0] : 1'b0;
        m_led_power = (mode == 2'b00 && CH >= 2) ? {1'b1, pw[1]} : 2'b00;
        m_led_disk  = (mode == 2'b00 && CH >= 3) ? {1'b1, pw[2]} : 2'b00;
        if (mode != 2'b01) begin
            m_active = 0; m_user_out = 7'h7F; m_busy = 0;
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t == 2*SD*NB + SD) m_active = 0;
            end else if (m_cnt == 0) begin
                m_active = 1; m_t = 0; m_bits = lamp_bits();
            end
            if (!m_active) begin
                m_user_out = 7'h78; m_busy = 0;
            end else begin
                m_busy = 1;
                if (m_t < 2*SD*NB)
                    m_user_out = {4'hF, 1'b0, ((m_t % (2*SD)) >= SD), m_bits[NB-1-m_t/(2*SD)]};
                else
                    m_user_out = 7'h7C;
            end
        end
        if (sample_ce) begin
            for (int i = 0; i < CH; i++) begin
                dec = m_env[i] - (m_env[i] >> DS);
                lv  = int'(level[i*LW +: LW]);
                m_env[i] = (lv > dec) ? lv : dec;
            end
        end
        m_cnt = (m_cnt + 1) % (1 << PW);
    endtask

    task automatic compare_all();
        check("led_user",  led_user,  m_led_user);
        check("led_power", led_power, m_led_power);
        check("led_disk",  led_disk,  m_led_disk);
        check("user_out",  user_out,  m_user_out);
        check("busy",      busy,      m_busy);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        @(negedge clk_sys);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_ce = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wait_busy(input int limit, output int waited);
        waited = 0;
        while (busy !== 1'b1 && waited < limit) begin tick(); waited++; end
        check("wait_busy_timeout", (waited < limit), 1);
    endtask

    task automatic capture_frame(output logic [NB-1:0] bits, output int nbusy,
                                 output int nlatch, output int nclk);
        int   waited, guard;
        logic prev_sclk;
        bits = '0; nbusy = 0; nlatch = 0; nclk = 0; guard = 0; prev_sclk = 1'b0;
        wait_busy(300, waited);
        while (busy === 1'b1 && guard < 200) begin
            nbusy++;
            if (user_out[2]) nlatch++;
            if (user_out[1] && !prev_sclk) begin bits = {bits[NB-2:0], user_out[0]}; nclk++; end
            prev_sclk = user_out[1];
            tick(); guard++;
        end
        check("frame_end_timeout", (guard < 200), 1);
    endtask

    task automatic load_env(input logic [CH*LW-1:0] lv);
        level = lv; sample_ce = 1'b1; tick();
        sample_ce = 1'b0; level = '0;
    endtask

    initial begin
        logic [NB-1:0] bits;
        int nbusy, nlatch, nclk, high, waited, guard, latch_seen;

        reset = 1'b1; sample_ce = 1'b0; level = '0; mode = 2'b00;
        do_reset();
        check("rst_user_out", user_out, 7'h7F);
        check("rst_busy", busy, 0);
        check("rst_led_power", led_power, 2'b00);

        // Mode 00 duty cycle at half scale.
        load_env({8'h00, 8'h00, 8'h80});
        check("model_env0_80", m_env[0], 32'h80);
        high = 0;
        for (int c = 0; c < 256; c++) begin tick(); if (led_user) high++; end
        check("duty_0x80", high, 128);
        check("led_power_hi", led_power[1], 1);

        // Decay then max-wins.
        load_env('0);
        check("model_decay1", m_env[0], 32'h70);
        load_env('0);
        check("model_decay2", m_env[0], 32'h62);
        load_env({8'h00, 8'h00, 8'h65});
        check("model_maxwins", m_env[0], 32'h65);
        high = 0;
        for (int c = 0; c < 256; c++) begin tick(); if (led_user) high++; end
        check("duty_0x65", high, 101);

        // Serial frame for {FF,40,00}.
        do_reset();
        mode = 2'b10;
        load_env({8'hFF, 8'h40, 8'h00});
        check("off_led_power", led_power, 2'b00);
        mode = 2'b01;
        capture_frame(bits, nbusy, nlatch, nclk);
        check("frame_bits", bits, 12'hF10);
        check("frame_nclk", nclk, 12);
        check("frame_busy", nbusy, 50);
        check("frame_latch", nlatch, 2);
        check("idle_user_out", user_out, 7'h78);

        // Smallest lit envelope, then all dark.
        do_reset();
        mode = 2'b10;
        load_env({8'h00, 8'h00, 8'h01});
        mode = 2'b01;
        capture_frame(bits, nbusy, nlatch, nclk);
        check("lamp_env1", bits, 12'h001);
        do_reset();
        capture_frame(bits, nbusy, nlatch, nclk);
        check("lamp_env0", bits, 12'h000);

        // Abort mid-transfer, then restart on the next counter wrap.
        do_reset();
        load_env({8'hFF, 8'h80, 8'hC0});
        wait_busy(300, waited);
        nclk = 0; guard = 0;
        while (nclk < 6 && guard < 100) begin
            if (user_out[1]) nclk++;
            tick(); guard++;
        end
        mode = 2'b10;
        tick();
        check("abort_user_out", user_out, 7'h7F);
        check("abort_busy", busy, 0);
        check("abort_led_user", led_user, 0);
        mode = 2'b01;
        wait_busy(300, waited);
        check("restart_within_wrap", (waited <= 256), 1);

        // Reset mid-shift: no latch pulse.
        tick(); tick(); tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_user_out", user_out, 7'h7F);
        check("midrst_busy", busy, 0);
        latch_seen = 0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin tick(); if (user_out[2]) latch_seen++; end
        check("midrst_no_latch", latch_seen, 0);

        // Randomized traffic.
        for (int c = 0; c < 5000; c++) begin
            sample_ce = ($urandom_range(0, 3) == 0);
            level     = (CH*LW)'($urandom());
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 1) mode = 2'b01;
            reset     = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
